// File: rtl/mig_traffic_gen_if.sv
// Bus bundle between the chunk stacker / unstacker streams, the MIG app_* port
// and mig_traffic_gen. The master view is the traffic generator itself.
interface mig_traffic_gen_if #(
    parameter int ADDR_W = 27
);
    logic              chunk_tvalid;
    logic              chunk_tready;
    logic [127:0]      chunk_tdata;
    logic              chunk_tlast;

    logic              rd_fifo_ready;
    logic              rd_tvalid;
    logic [127:0]      rd_tdata;
    logic              rd_tlast;

    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [127:0]      app_wdf_data;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [15:0]       app_wdf_mask;
    logic              app_wdf_rdy;
    logic [127:0]      app_rd_data;
    logic              app_rd_data_valid;

    modport master (
        input  chunk_tvalid, chunk_tdata, chunk_tlast, rd_fifo_ready,
               app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        output chunk_tready, rd_tvalid, rd_tdata, rd_tlast,
               app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
               app_wdf_end, app_wdf_mask
    );

    modport slave (
        output chunk_tvalid, chunk_tdata, chunk_tlast, rd_fifo_ready,
               app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        input  chunk_tready, rd_tvalid, rd_tdata, rd_tlast,
               app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
               app_wdf_end, app_wdf_mask
    );
endinterface

// File: rtl/mig_traffic_gen.sv
// Writes 128-bit chunks linearly into DDR through the MIG app_* port and reads
// the frame back continuously; writes win arbitration, reads are credit-bounded.
module mig_traffic_gen #(
    parameter int ADDR_W          = 27,
    parameter int ADDR_STEP       = 8,
    parameter int FRAME_CHUNKS    = 230400,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              calib_done_in,
    mig_traffic_gen_if.master bus
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = (FRAME_CHUNKS > 1) ? $clog2(FRAME_CHUNKS) : 1;
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((FRAME_CHUNKS - 1) * ADDR_STEP);
    localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              cmd_done_q, cmd_done_d;
    logic              dat_done_q, dat_done_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  rd_ret_cnt_q, rd_ret_cnt_d;
    logic              rd_tvalid_q, rd_tlast_q;
    logic [127:0]      rd_tdata_q;

    logic cmd_hs, dat_hs, wr_fin, rd_hs, ret_dec;

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Strobes are derived from state so reset drops them without waiting for a clock.
    always_comb begin
        bus.app_en       = 1'b0;
        bus.app_wdf_wren = 1'b0;
        bus.app_cmd      = 3'b000;
        bus.app_addr     = '0;
        case (state_q)
            WR: begin
                bus.app_en       = !cmd_done_q;
                bus.app_wdf_wren = !dat_done_q;
                bus.app_addr     = wr_addr_q;
            end
            RD: begin
                bus.app_en   = 1'b1;
                bus.app_cmd  = 3'b001;
                bus.app_addr = rd_addr_q;
            end
            default: ;
        endcase
    end

    assign cmd_hs  = bus.app_en && bus.app_rdy;
    assign dat_hs  = bus.app_wdf_wren && bus.app_wdf_rdy;
    assign wr_fin  = (state_q == WR) && (cmd_done_q || cmd_hs) && (dat_done_q || dat_hs);
    assign rd_hs   = (state_q == RD) && bus.app_rdy;
    assign ret_dec = bus.app_rd_data_valid && (outstanding_q != '0);

    assign bus.chunk_tready = wr_fin;
    assign bus.app_wdf_data = bus.chunk_tdata;
    assign bus.app_wdf_end  = bus.app_wdf_wren;
    assign bus.app_wdf_mask = '0;
    assign bus.rd_tvalid    = rd_tvalid_q;
    assign bus.rd_tdata     = rd_tdata_q;
    assign bus.rd_tlast     = rd_tlast_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (calib_done_in) begin
                    if (bus.chunk_tvalid)
                        state_d = WR;
                    else if (bus.rd_fifo_ready && outstanding_q < OUT_MAX)
                        state_d = RD;
                end
            end
            WR:      if (wr_fin) state_d = IDLE;
            RD:      if (rd_hs)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_done_d    = 1'b0;
        dat_done_d    = 1'b0;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        outstanding_d = outstanding_q;
        rd_ret_cnt_d  = rd_ret_cnt_q;
        if (state_q == WR && !wr_fin) begin
            cmd_done_d = cmd_done_q || cmd_hs;
            dat_done_d = dat_done_q || dat_hs;
        end
        // A frame ends either on the stacker's tlast or on the last address slot.
        if (wr_fin)
            wr_addr_d = (bus.chunk_tlast || wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + STEP;
        if (rd_hs)
            rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + STEP;
        case ({rd_hs, ret_dec})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: ;
        endcase
        if (bus.app_rd_data_valid)
            rd_ret_cnt_d = (rd_ret_cnt_q == CNT_LAST) ? '0 : rd_ret_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            cmd_done_q    <= 1'b0;
            dat_done_q    <= 1'b0;
            outstanding_q <= '0;
            rd_ret_cnt_q  <= '0;
            rd_tvalid_q   <= 1'b0;
            rd_tlast_q    <= 1'b0;
            rd_tdata_q    <= '0;
        end else begin
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            cmd_done_q    <= cmd_done_d;
            dat_done_q    <= dat_done_d;
            outstanding_q <= outstanding_d;
            rd_ret_cnt_q  <= rd_ret_cnt_d;
            rd_tvalid_q   <= bus.app_rd_data_valid;
            rd_tdata_q    <= bus.app_rd_data;
            rd_tlast_q    <= bus.app_rd_data_valid && (rd_ret_cnt_q == CNT_LAST);
        end
    end
endmodule

// File: tb/tb_mig_traffic_gen.sv
// Bench for mig_traffic_gen: table of write chunks with handshake delays,
// hand-written outstanding/reset sequences, randomized read traffic vs a model.
module tb_mig_traffic_gen;
    localparam int ADDR_W = 27;
    localparam int STEP   = 8;
    localparam int FC     = 4;
    localparam int MAXO   = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    logic calib_done_in;
    always #5 clk_in = ~clk_in;

    mig_traffic_gen_if #(.ADDR_W(ADDR_W)) bus ();

    mig_traffic_gen #(
        .ADDR_W(ADDR_W), .ADDR_STEP(STEP), .FRAME_CHUNKS(FC), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .calib_done_in(calib_done_in), .bus(bus)
    );

    typedef struct {
        logic [127:0]      data;
        logic              last;
        int                rdy_dly;
        int                wdf_dly;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    vec_t tbl [8];

    int n_cmp = 0;
    int n_err = 0;

    // monitor / model state
    int           en_any, en_cyc, wr_cyc, trdy_cnt;
    int           rd_issued = 0, ret_cnt = 0, model_out = 0;
    logic [ADDR_W-1:0] w_addr;
    logic [127:0] w_data;
    logic [127:0] pending[$];
    logic         prev_v = 1'b0, prev_l = 1'b0;
    logic [127:0] prev_d = '0;
    logic         auto_ret = 1'b0;
    int           ret_grant = 0, ret_done = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] v);
        return {v, ~v, v ^ 32'h5A5A_5A5A, v + 32'h1};
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Observes every handshake on the falling edge, when all strobes are settled.
    always @(negedge clk_in) if (rst_in) begin
        if (bus.app_en) en_any++;
        if (bus.app_en && bus.app_cmd == 3'b000) begin
            en_cyc++;
            if (bus.app_rdy) w_addr = bus.app_addr;
        end
        if (bus.app_wdf_wren) begin
            wr_cyc++;
            chk("wdf_end", 128'(bus.app_wdf_end), 128'(1));
            chk("wdf_mask", 128'(bus.app_wdf_mask), 128'(0));
            if (bus.app_wdf_rdy) w_data = bus.app_wdf_data;
        end
        if (bus.chunk_tready) trdy_cnt++;
        if (bus.app_en && bus.app_rdy && bus.app_cmd == 3'b001) begin
            chk("rd_cmd_addr", 128'(bus.app_addr), 128'((rd_issued % FC) * STEP));
            chk("rd_out_bound", 128'(model_out < MAXO), 128'(1));
            pending.push_back({64'(rd_issued), 64'(bus.app_addr)});
            rd_issued++;
            model_out++;
        end
        if (prev_v || bus.rd_tvalid) begin
            chk("rd_tvalid", 128'(bus.rd_tvalid), 128'(prev_v));
            chk("rd_tdata", bus.rd_tdata, prev_d);
            chk("rd_tlast", 128'(bus.rd_tlast), 128'(prev_l));
        end
        prev_v = bus.app_rd_data_valid;
        prev_d = bus.app_rd_data;
        prev_l = bus.app_rd_data_valid && (ret_cnt % FC == FC - 1);
        if (bus.app_rd_data_valid) begin
            ret_cnt++;
            if (model_out > 0) model_out--;
        end
    end

    // MIG read-return model: echoes the issued address, in order.
    initial begin
        bus.app_rd_data_valid = 1'b0;
        bus.app_rd_data       = '0;
        forever begin
            cyc();
            bus.app_rd_data_valid = 1'b0;
            if (pending.size() > 0 &&
                (auto_ret ? ($urandom_range(0, 1) == 0) : (ret_done < ret_grant))) begin
                bus.app_rd_data_valid = 1'b1;
                bus.app_rd_data       = pending.pop_front();
                ret_done++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{mk(32'hA),  1'b0, 0, 0, 27'd0};
        tbl[1] = '{mk(32'hB),  1'b0, 0, 0, 27'd8};
        tbl[2] = '{mk(32'hC),  1'b0, 0, 0, 27'd16};
        tbl[3] = '{mk(32'hD),  1'b0, 0, 0, 27'd24};
        tbl[4] = '{mk(32'hE),  1'b0, 3, 0, 27'd0};
        tbl[5] = '{mk(32'hF),  1'b0, 0, 3, 27'd8};
        tbl[6] = '{mk(32'h10), 1'b1, 2, 2, 27'd16};
        tbl[7] = '{mk(32'h11), 1'b0, 1, 0, 27'd0};

        rst_in = 1'b0;
        calib_done_in = 1'b0;
        bus.chunk_tvalid = 1'b0;
        bus.chunk_tdata  = '0;
        bus.chunk_tlast  = 1'b0;
        bus.rd_fifo_ready = 1'b0;
        bus.app_rdy      = 1'b0;
        bus.app_wdf_rdy  = 1'b0;
        repeat (3) cyc();

        chk("rst_app_en", 128'(bus.app_en), 128'(0));
        chk("rst_wdf_wren", 128'(bus.app_wdf_wren), 128'(0));
        chk("rst_chunk_tready", 128'(bus.chunk_tready), 128'(0));
        chk("rst_rd_tvalid", 128'(bus.rd_tvalid), 128'(0));
        chk("rst_rd_tlast", 128'(bus.rd_tlast), 128'(0));
        chk("rst_rd_tdata", bus.rd_tdata, 128'(0));
        chk("rst_app_addr", 128'(bus.app_addr), 128'(0));
        chk("rst_app_cmd", 128'(bus.app_cmd), 128'(0));

        // Pending chunk must be ignored until calibration completes.
        en_any = 0; trdy_cnt = 0;
        rst_in = 1'b1;
        bus.chunk_tvalid = 1'b1;
        bus.chunk_tdata  = tbl[0].data;
        bus.app_rdy = 1'b1;
        bus.app_wdf_rdy = 1'b1;
        repeat (50) cyc();
        chk("calib_hold_en", 128'(en_any), 128'(0));
        chk("calib_hold_tready", 128'(trdy_cnt), 128'(0));
        calib_done_in = 1'b1;

        for (int i = 0; i < 8; i++) begin
            en_cyc = 0; wr_cyc = 0; trdy_cnt = 0;
            w_addr = '1; w_data = '1;
            bus.chunk_tvalid = 1'b1;
            bus.chunk_tdata  = tbl[i].data;
            bus.chunk_tlast  = tbl[i].last;
            bus.app_rdy      = (tbl[i].rdy_dly == 0);
            bus.app_wdf_rdy  = (tbl[i].wdf_dly == 0);
            for (int c = 0; c < 60 && trdy_cnt == 0; c++) begin
                cyc();
                bus.app_rdy     = (en_cyc >= tbl[i].rdy_dly);
                bus.app_wdf_rdy = (wr_cyc >= tbl[i].wdf_dly);
            end
            bus.chunk_tvalid = 1'b0;
            bus.chunk_tlast  = 1'b0;
            cyc();
            chk($sformatf("wr%0d_tready_pulses", i), 128'(trdy_cnt), 128'(1));
            chk($sformatf("wr%0d_addr", i), 128'(w_addr), 128'(tbl[i].exp_addr));
            chk($sformatf("wr%0d_data", i), w_data, tbl[i].data);
            chk($sformatf("wr%0d_en_cycles", i), 128'(en_cyc), 128'(tbl[i].rdy_dly + 1));
            chk($sformatf("wr%0d_wren_cycles", i), 128'(wr_cyc), 128'(tbl[i].wdf_dly + 1));
        end

        // Outstanding bound with read data withheld.
        bus.app_rdy = 1'b1;
        bus.rd_fifo_ready = 1'b1;
        repeat (30) cyc();
        chk("stall_issued", 128'(rd_issued), 128'(MAXO));
        ret_grant++;
        repeat (20) cyc();
        chk("one_return_issued", 128'(rd_issued), 128'(MAXO + 1));
        bus.rd_fifo_ready = 1'b0;
        ret_grant += 2;
        repeat (20) cyc();
        chk("fifo_not_ready_issued", 128'(rd_issued), 128'(MAXO + 1));
        chk("stall_drained", 128'(pending.size()), 128'(0));

        // Randomized continuous read-back.
        auto_ret = 1'b1;
        for (int c = 0; c < 600; c++) begin
            cyc();
            bus.rd_fifo_ready = ($urandom_range(0, 3) != 0);
            bus.app_rdy       = ($urandom_range(0, 1) == 1);
        end
        bus.rd_fifo_ready = 1'b0;
        bus.app_rdy = 1'b1;
        repeat (40) cyc();
        chk("rand_progress", 128'(rd_issued >= 40), 128'(1));
        chk("rand_drained", 128'(pending.size()), 128'(0));
        chk("rand_outstanding", 128'(model_out), 128'(0));
        chk("rand_returns", 128'(ret_cnt), 128'(rd_issued));

        // Reset in the middle of a write.
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b0;
        bus.chunk_tvalid = 1'b1;
        bus.chunk_tdata = mk(32'h77);
        for (int c = 0; c < 20 && !bus.app_en; c++) cyc();
        cyc();
        chk("midwr_en", 128'(bus.app_en), 128'(1));
        chk("midwr_addr", 128'(bus.app_addr), 128'(8));
        #2 rst_in = 1'b0;
        #1;
        chk("midwr_rst_en", 128'(bus.app_en), 128'(0));
        chk("midwr_rst_wren", 128'(bus.app_wdf_wren), 128'(0));
        chk("midwr_rst_tready", 128'(bus.chunk_tready), 128'(0));
        chk("midwr_rst_addr", 128'(bus.app_addr), 128'(0));
        chk("midwr_rst_rd_tvalid", 128'(bus.rd_tvalid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
